// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: Morse key stream to active-low 7-segment characters with a shifting history.
// Define MORSE_ERR_CHAR_EN to emit a dash glyph for invalid patterns instead of dropping them.
module morse_stream_decoder #(
    parameter int DOT_MAX    = 3,
    parameter int LETTER_GAP = 6,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               key_in,
    input  logic               clear,
    output logic               char_valid,
    output logic [6:0]         char_seg,
    output logic               char_err,
    output logic [7*DEPTH-1:0] history,
    output logic               busy
);
`ifdef MORSE_ERR_CHAR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam int PW = $clog2(DOT_MAX + 2);
    localparam int GW = $clog2(LETTER_GAP + 1);
    localparam logic [6:0] ERR_SEG = 7'b0111111;

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      press_q, press_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [2:0]         len_q, len_d;
    logic [4:0]         pat_q, pat_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [6:0]         seg_q, seg_d;
    logic               err_q, err_d;
    logic [7*DEPTH-1:0] hist_q, hist_d;
    logic [6:0]         code, out_seg;
    logic               known, inv;

    // Siekoo glyphs, segment order {g,f,e,d,c,b,a}; element k of the character sits in pattern bit k
    always_comb begin
        code  = 7'h7f;
        known = 1'b1;
        case ({len_q, pat_q})
            {3'd1, 5'b00000}: code = ~7'h79;
            {3'd1, 5'b00001}: code = ~7'h78;
            {3'd2, 5'b00000}: code = ~7'h30;
            {3'd2, 5'b00010}: code = ~7'h77;
            {3'd2, 5'b00001}: code = ~7'h54;
            {3'd2, 5'b00011}: code = ~7'h55;
            {3'd3, 5'b00000}: code = ~7'h2d;
            {3'd3, 5'b00100}: code = ~7'h1c;
            {3'd3, 5'b00010}: code = ~7'h50;
            {3'd3, 5'b00110}: code = ~7'h2a;
            {3'd3, 5'b00001}: code = ~7'h5e;
            {3'd3, 5'b00101}: code = ~7'h75;
            {3'd3, 5'b00011}: code = ~7'h3d;
            {3'd3, 5'b00111}: code = ~7'h5c;
            {3'd4, 5'b00000}: code = ~7'h74;
            {3'd4, 5'b01000}: code = ~7'h3e;
            {3'd4, 5'b00100}: code = ~7'h71;
            {3'd4, 5'b00010}: code = ~7'h38;
            {3'd4, 5'b00110}: code = ~7'h73;
            {3'd4, 5'b01110}: code = ~7'h0e;
            {3'd4, 5'b00001}: code = ~7'h7c;
            {3'd4, 5'b01001}: code = ~7'h76;
            {3'd4, 5'b00101}: code = ~7'h58;
            {3'd4, 5'b01101}: code = ~7'h6e;
            {3'd4, 5'b00011}: code = ~7'h1b;
            {3'd4, 5'b01011}: code = ~7'h67;
            {3'd5, 5'b11111}: code = ~7'h3f;
            {3'd5, 5'b11110}: code = ~7'h06;
            {3'd5, 5'b11100}: code = ~7'h5b;
            {3'd5, 5'b11000}: code = ~7'h4f;
            {3'd5, 5'b10000}: code = ~7'h66;
            {3'd5, 5'b00000}: code = ~7'h6d;
            {3'd5, 5'b00001}: code = ~7'h7d;
            {3'd5, 5'b00011}: code = ~7'h07;
            {3'd5, 5'b00111}: code = ~7'h7f;
            {3'd5, 5'b01111}: code = ~7'h6f;
            default:          known = 1'b0;
        endcase
    end

    assign inv     = ovf_q | ~known;
    assign out_seg = inv ? ERR_SEG : code;

    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        seg_d   = seg_q;
        err_d   = err_q;
        hist_d  = hist_q;
        case (state_q)
            IDLE: begin
                if (key_in) begin
                    state_d = PRESS;
                    press_d = '0;
                end
            end
            PRESS: begin
                if (!key_in) begin
                    state_d = GAP;
                    gap_d   = '0;
                    if (len_q == 3'd5) ovf_d = 1'b1;
                    else begin
                        pat_d[len_q] = press_q > PW'(DOT_MAX);
                        len_d        = len_q + 3'd1;
                    end
                end else if (tick && press_q != PW'(DOT_MAX + 1)) press_d = press_q + 1'b1;
            end
            GAP: begin
                if (key_in) begin
                    state_d = PRESS;
                    press_d = '0;
                end else if (tick) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GW'(LETTER_GAP - 1)) state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = IDLE;
                len_d   = '0;
                pat_d   = '0;
                ovf_d   = 1'b0;
                if (!inv || ERR_EN) begin
                    valid_d = 1'b1;
                    seg_d   = out_seg;
                    err_d   = inv & ERR_EN;
                    hist_d  = (7*DEPTH)'({hist_q, out_seg});
                end
            end
        endcase
        if (clear) begin
            state_d = IDLE;
            press_d = '0;
            gap_d   = '0;
            len_d   = '0;
            pat_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            seg_d   = seg_q;
            err_d   = err_q;
            hist_d  = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            press_q <= '0;
            gap_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            seg_q   <= 7'h7f;
            err_q   <= 1'b0;
            hist_q  <= '1;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            gap_q   <= gap_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
        end
    end

    assign char_valid = valid_q;
    assign char_seg   = seg_q;
    assign char_err   = err_q;
    assign history    = hist_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: directed and random Morse characters checked against a dictionary-based model.
module tb_morse_stream_decoder;
    localparam int DOT_MAX    = 3;
    localparam int LETTER_GAP = 6;
    localparam int DEPTH      = 4;
`ifdef MORSE_ERR_CHAR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, tick, key_in, clear, char_valid, char_err, busy;
    logic [6:0] char_seg;
    logic [7*DEPTH-1:0] history;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [6:0] tab[string];
    string keys[$];
    logic [6:0] hq[$];
    logic [6:0] last_seg = 7'h7f;
    logic last_err = 1'b0;

    always #5 clk = ~clk;

    morse_stream_decoder #(.DOT_MAX(DOT_MAX), .LETTER_GAP(LETTER_GAP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(key_in), .clear(clear),
        .char_valid(char_valid), .char_seg(char_seg), .char_err(char_err),
        .history(history), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input string s, input logic [6:0] glyph);
        tab[s] = glyph;
        keys.push_back(s);
    endtask

    function automatic logic [7*DEPTH-1:0] hist_exp();
        logic [7*DEPTH-1:0] r;
        for (int i = 0; i < DEPTH; i++) r[7*i +: 7] = (i < hq.size()) ? hq[i] : 7'h7f;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (char_valid === 1'b1) pulses++;
    endtask

    // Keys one character; dots last 1..4 cycles, dashes 5..8, inner gaps 1..5 (fixed 2/5/3 when not random)
    task automatic send(input string s, input bit rnd);
        bit bad, emit;
        int first;
        logic [6:0] code, seg_c;
        logic err_c;
        pulses = 0;
        seg_c = 'x;
        err_c = 'x;
        for (int i = 0; i < s.len(); i++) begin
            key_in = 1'b1;
            repeat (s[i] == "-" ? (rnd ? $urandom_range(5, 8) : 5) : (rnd ? $urandom_range(1, 4) : 2)) step();
            key_in = 1'b0;
            if (i < s.len() - 1) repeat (rnd ? $urandom_range(1, 5) : 3) step();
        end
        chk($sformatf("mid_pulse[%s]", s), pulses, 0);
        bad = s.len() > 5 || !tab.exists(s);
        code = 7'b0111111;
        if (!bad) code = ~tab[s];
        emit = !bad || ERR_EN;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (char_valid === 1'b1 && first == 0) begin
                first = i;
                seg_c = char_seg;
                err_c = char_err;
            end
        end
        if (emit) begin
            hq.push_front(code);
            if (hq.size() > DEPTH) void'(hq.pop_back());
            last_seg = code;
            last_err = bad;
            chk($sformatf("latency[%s]", s), first, LETTER_GAP + 2);
            chk($sformatf("seg[%s]", s), seg_c, code);
            chk($sformatf("err[%s]", s), err_c, bad);
        end else chk($sformatf("no_emit[%s]", s), first, 0);
        chk($sformatf("pulses[%s]", s), pulses, emit ? 1 : 0);
        chk($sformatf("seg_hold[%s]", s), char_seg, last_seg);
        chk($sformatf("err_hold[%s]", s), char_err, last_err);
        chk($sformatf("history[%s]", s), history, hist_exp());
        chk($sformatf("busy_end[%s]", s), busy, 0);
    endtask

    initial begin
        string s, e;
        add(".", 7'h79);     add("-", 7'h78);     add("..", 7'h30);    add(".-", 7'h77);
        add("-.", 7'h54);    add("--", 7'h55);    add("...", 7'h2d);   add("..-", 7'h1c);
        add(".-.", 7'h50);   add(".--", 7'h2a);   add("-..", 7'h5e);   add("-.-", 7'h75);
        add("--.", 7'h3d);   add("---", 7'h5c);   add("....", 7'h74);  add("...-", 7'h3e);
        add("..-.", 7'h71);  add(".-..", 7'h38);  add(".--.", 7'h73);  add(".---", 7'h0e);
        add("-...", 7'h7c);  add("-..-", 7'h76);  add("-.-.", 7'h58);  add("-.--", 7'h6e);
        add("--..", 7'h1b);  add("--.-", 7'h67);  add("-----", 7'h3f); add(".----", 7'h06);
        add("..---", 7'h5b); add("...--", 7'h4f); add("....-", 7'h66); add(".....", 7'h6d);
        add("-....", 7'h7d); add("--...", 7'h07); add("---..", 7'h7f); add("----.", 7'h6f);

        rst_n = 1'b0; key_in = 1'b0; clear = 1'b0; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", char_valid, 0);
        chk("rst_err", char_err, 0);
        chk("rst_seg", char_seg, 7'h7f);
        chk("rst_history", history, {7*DEPTH{1'b1}});
        chk("rst_busy", busy, 0);

        send(".", 0);
        send(".-", 0);
        send(".----", 0);
        send("......", 0);
        send(".", 0); send("-", 0); send(".", 0); send("-", 0); send(".", 0);
        chk("hist_etete", history, {~7'h78, ~7'h79, ~7'h78, ~7'h79});

        pulses = 0;
        key_in = 1'b1;
        repeat (3) step();
        chk("clear_pre_busy", busy, 1);
        clear = 1'b1; key_in = 1'b0;
        step();
        clear = 1'b0;
        hq.delete();
        chk("clear_busy", busy, 0);
        chk("clear_history", history, {7*DEPTH{1'b1}});
        chk("clear_valid", char_valid, 0);
        chk("clear_seg", char_seg, last_seg);
        chk("clear_err", char_err, last_err);
        repeat (12) step();
        chk("clear_pulses", pulses, 0);

        send("-", 0);
        pulses = 0;
        key_in = 1'b1;
        repeat (2) step();
        key_in = 1'b0;
        repeat (3) step();
        chk("gap_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        hq.delete();
        last_seg = 7'h7f;
        last_err = 1'b0;
        chk("arst_busy", busy, 0);
        chk("arst_history", history, {7*DEPTH{1'b1}});
        chk("arst_seg", char_seg, 7'h7f);
        chk("arst_valid", char_valid, 0);
        step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("arst_pulses", pulses, 0);
        chk("arst_busy_after", busy, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) s = keys[$urandom_range(0, keys.size() - 1)];
            else begin
                s = "";
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                    e = ($urandom_range(0, 1) == 1) ? "-" : ".";
                    s = {s, e};
                end
            end
            send(s, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
